// File: rtl/jstk_poll_scheduler.sv
// Round-robin poller that shares one byte-level SPI master between two PmodJSTK2
// joysticks and publishes each device's X/Y/button fields atomically.
module jstk_poll_scheduler #(
  parameter int SS_SETUP_CYC = 1500,
  parameter int BYTE_GAP_CYC = 1000,
  parameter int POLL_GAP_CYC = 100000,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,          // active low, synchronous
  input  logic [1:0]  i_dev_en,
  output logic        o_spi_start,
  output logic [7:0]  o_spi_tx_byte,
  input  logic        i_spi_done,
  input  logic [7:0]  i_spi_rx_byte,
  output logic [1:0]  o_ss,
  output logic [10:0] o_dev0_x,
  output logic [10:0] o_dev0_y,
  output logic [10:0] o_dev1_x,
  output logic [10:0] o_dev1_y,
  output logic [1:0]  o_dev0_btn,
  output logic [1:0]  o_dev1_btn,
  output logic [1:0]  o_upd,
  output logic [1:0]  o_err
);

  localparam int MAX_AB  = (SS_SETUP_CYC > BYTE_GAP_CYC) ? SS_SETUP_CYC : BYTE_GAP_CYC;
  localparam int MAX_CD  = (POLL_GAP_CYC > TIMEOUT_CYC) ? POLL_GAP_CYC : TIMEOUT_CYC;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] BGAP_LAST  = CNT_W'(BYTE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_GAP, S_SETUP, S_START, S_WAIT, S_BGAP, S_RELEASE, S_COMMIT
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cur_dev;
  logic              r_ok;
  logic [2:0]        r_idx;
  logic [4:0][7:0]   r_shadow;
  logic              r_spi_start;
  logic [1:0]        r_ss;
  logic [1:0][10:0]  r_x;
  logic [1:0][10:0]  r_y;
  logic [1:0][1:0]   r_btn;
  logic [1:0]        r_upd;
  logic [1:0]        r_err;

  logic              w_any_en;
  logic              w_next_dev;
  logic [10:0]       w_x;
  logic [10:0]       w_y;
  logic [1:0]        w_btn;

  // Prefer the other device; fall back to the current one if it is the only one enabled.
  assign w_any_en   = |i_dev_en;
  assign w_next_dev = i_dev_en[~r_cur_dev] ? ~r_cur_dev : r_cur_dev;

  assign w_x   = {1'b0, r_shadow[1][1:0], r_shadow[0]};
  assign w_y   = {1'b0, r_shadow[3][1:0], r_shadow[2]};
  assign w_btn = r_shadow[4][1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_GAP;
      r_cnt       <= '0;
      r_cur_dev   <= 1'b0;
      r_ok        <= 1'b0;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_spi_start <= 1'b0;
      r_ss        <= 2'b11;
      r_x         <= '0;
      r_y         <= '0;
      r_btn       <= '0;
      r_upd       <= '0;
      r_err       <= '0;
    end else begin
      r_spi_start <= 1'b0;
      r_upd       <= '0;
      r_err       <= '0;
      case (r_state)
        S_GAP: begin
          if (r_cnt != POLL_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_any_en) begin
            r_cur_dev <= w_next_dev;
            r_ss      <= w_next_dev ? 2'b01 : 2'b10;
            r_cnt     <= '0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_spi_start <= 1'b1;
            r_state     <= S_START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last timeout cycle still counts as success.
          if (i_spi_done) begin
            r_shadow[r_idx] <= i_spi_rx_byte;
            r_cnt           <= '0;
            if (r_idx == 3'd4) begin
              r_ok    <= 1'b1;
              r_ss    <= 2'b11;
              r_state <= S_RELEASE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_BGAP;
            end
          end else if (r_cnt == TOUT_LAST) begin
            r_ok              <= 1'b0;
            r_ss              <= 2'b11;
            r_err[r_cur_dev]  <= 1'b1;
            r_cnt             <= '0;
            r_state           <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BGAP: begin
          if (r_cnt == BGAP_LAST) begin
            r_cnt       <= '0;
            r_spi_start <= 1'b1;
            r_state     <= S_START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          r_cnt <= '0;
          if (r_ok) begin
            r_x[r_cur_dev]   <= w_x;
            r_y[r_cur_dev]   <= w_y;
            r_btn[r_cur_dev] <= w_btn;
            r_upd[r_cur_dev] <= 1'b1;
            r_state          <= S_COMMIT;
          end else begin
            r_state <= S_GAP;
          end
        end
        S_COMMIT: begin
          r_cnt   <= '0;
          r_state <= S_GAP;
        end
        default: begin
          r_cnt   <= '0;
          r_ss    <= 2'b11;
          r_state <= S_GAP;
        end
      endcase
    end
  end

  // Selects deassert as soon as reset is applied, without waiting for the clock.
  assign o_ss          = i_rst ? r_ss : 2'b11;
  assign o_spi_start   = r_spi_start;
  assign o_spi_tx_byte = 8'h00;
  assign o_dev0_x      = r_x[0];
  assign o_dev0_y      = r_y[0];
  assign o_dev1_x      = r_x[1];
  assign o_dev1_y      = r_y[1];
  assign o_dev0_btn    = r_btn[0];
  assign o_dev1_btn    = r_btn[1];
  assign o_upd         = r_upd;
  assign o_err         = r_err;

endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// Directed bench for jstk_poll_scheduler: table of poll transactions plus
// hand-written reset and timing sequences.
module tb_jstk_poll_scheduler;
  localparam int SETUP = 4;
  localparam int BGAP  = 3;
  localparam int POLL  = 8;
  localparam int TOUT  = 50;

  logic        clk;
  logic        rst;
  logic [1:0]  dev_en;
  logic        spi_start;
  logic [7:0]  spi_tx_byte;
  logic        spi_done;
  logic [7:0]  spi_rx_byte;
  logic [1:0]  ss;
  logic [10:0] dev0_x, dev0_y, dev1_x, dev1_y;
  logic [1:0]  dev0_btn, dev1_btn, upd, err;

  jstk_poll_scheduler #(
    .SS_SETUP_CYC(SETUP), .BYTE_GAP_CYC(BGAP), .POLL_GAP_CYC(POLL), .TIMEOUT_CYC(TOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_dev_en(dev_en),
    .o_spi_start(spi_start), .o_spi_tx_byte(spi_tx_byte),
    .i_spi_done(spi_done), .i_spi_rx_byte(spi_rx_byte), .o_ss(ss),
    .o_dev0_x(dev0_x), .o_dev0_y(dev0_y), .o_dev1_x(dev1_x), .o_dev1_y(dev1_y),
    .o_dev0_btn(dev0_btn), .o_dev1_btn(dev1_btn), .o_upd(upd), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] en;
    logic [1:0] en_mid;
    int         dev;
    logic [7:0] b [5];
    int         drop;
    int         x, y, btn;
    bit         inj;
  } vec_t;

  vec_t tv [10];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_start = 0;
  bit   both_low = 1'b0;
  int   mx [2];
  int   my [2];
  int   mb [2];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (spi_start) n_start <= n_start + 1;
    if (ss == 2'b00) both_low <= 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] en, input logic [1:0] en_mid, input int dev,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input int drop,
                              input int x, input int y, input int btn, input bit inj);
    vec_t v;
    v.en = en; v.en_mid = en_mid; v.dev = dev;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    v.drop = drop; v.x = x; v.y = y; v.btn = btn; v.inj = inj;
    return v;
  endfunction

  function automatic int out_x(input int d);
    return d != 0 ? int'(dev1_x) : int'(dev0_x);
  endfunction
  function automatic int out_y(input int d);
    return d != 0 ? int'(dev1_y) : int'(dev0_y);
  endfunction
  function automatic int out_b(input int d);
    return d != 0 ? int'(dev1_btn) : int'(dev0_btn);
  endfunction

  task automatic wait_start(output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spi_start) begin
        c  = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at the negedge of the spi_start cycle s; done is high in cycle s+2.
  task automatic drive_done(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1 spi_done = 1'b1; spi_rx_byte = b;
    @(posedge clk);
    #1 spi_done = 1'b0; spi_rx_byte = 8'h00;
  endtask

  task automatic pulse_stray(input logic [7:0] b);
    @(posedge clk);
    #1 spi_done = 1'b1; spi_rx_byte = b;
    @(posedge clk);
    #1 spi_done = 1'b0; spi_rx_byte = 8'h00;
  endtask

  task automatic run_vec(input vec_t v);
    int f, s, d, n0, dv, od;
    bit ok;
    d = 0;
    dev_en = v.en;
    if (v.inj) pulse_stray(8'h55);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ss != 2'b11) begin ok = 1'b1; break; end
    end
    chk("ss_fall_seen", int'(ok), 1);
    if (!ok) return;
    f  = cyc;
    dv = (ss == 2'b01) ? 1 : 0;
    od = 1 - dv;
    chk("selected_dev", dv, v.dev);
    n0 = n_start;
    for (int k = 0; k < 5; k++) begin
      wait_start(s, ok);
      chk("spi_start_seen", int'(ok), 1);
      if (!ok) return;
      if (k == 0) chk("setup_spacing", s - f, SETUP);
      else        chk("byte_spacing", s - d, BGAP + 1);
      if (k == v.drop) begin
        repeat (TOUT) @(negedge clk);
        chk("ss_held_in_wait", int'(ss == 2'b11), 0);
        @(negedge clk);
        chk("timeout_ss", int'(ss), 3);
        chk("timeout_err", int'(err), 1 << dv);
        @(negedge clk);
        chk("err_one_cycle", int'(err), 0);
        chk("to_keep_x", out_x(dv), mx[dv]);
        chk("to_keep_y", out_y(dv), my[dv]);
        chk("to_keep_btn", out_b(dv), mb[dv]);
        chk("to_start_cnt", n_start - n0, k + 1);
        return;
      end
      drive_done(v.b[k]);
      d = s + 2;
      if (k == 1) dev_en = v.en_mid;
      if (v.inj && k < 4) pulse_stray(8'hAA);
    end
    @(negedge clk);
    chk("release_ss", int'(ss), 3);
    chk("release_no_upd", int'(upd), 0);
    @(negedge clk);
    chk("commit_upd", int'(upd), 1 << dv);
    chk("commit_x", out_x(dv), v.x);
    chk("commit_y", out_y(dv), v.y);
    chk("commit_btn", out_b(dv), v.btn);
    chk("other_x", out_x(od), mx[od]);
    chk("other_y", out_y(od), my[od]);
    chk("other_btn", out_b(od), mb[od]);
    chk("start_count", n_start - n0, 5);
    mx[dv] = v.x; my[dv] = v.y; mb[dv] = v.btn;
  endtask

  initial begin
    int s, n, first_ss;
    bit ok;
    rst = 1'b0; dev_en = 2'b00; spi_done = 1'b0; spi_rx_byte = 8'h00;
    for (int i = 0; i < 2; i++) begin mx[i] = 0; my[i] = 0; mb[i] = 0; end

    tv[0] = mk(2'b11, 2'b11, 1, 8'h10, 8'h01, 8'h20, 8'h02, 8'h01, -1,  272,  544, 1, 1'b1);
    tv[1] = mk(2'b11, 2'b11, 0, 8'h34, 8'h02, 8'hFF, 8'h01, 8'h03, -1,  564,  511, 3, 1'b0);
    tv[2] = mk(2'b11, 2'b11, 1, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, -1, 1023,  768, 3, 1'b1);
    tv[3] = mk(2'b11, 2'b11, 0, 8'h11, 8'h01, 8'h11, 8'h01, 8'h00,  2,    0,    0, 0, 1'b0);
    tv[4] = mk(2'b11, 2'b11, 1, 8'h00, 8'hFC, 8'h80, 8'hFE, 8'hFC, -1,    0,  640, 0, 1'b0);
    tv[5] = mk(2'b11, 2'b11, 0, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h02, -1,  383,    0, 2, 1'b0);
    tv[6] = mk(2'b10, 2'b10, 1, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01, -1,    1,    2, 1, 1'b0);
    tv[7] = mk(2'b10, 2'b10, 1, 8'h05, 8'h03, 8'h06, 8'h02, 8'h00, -1,  773,  518, 0, 1'b0);
    tv[8] = mk(2'b10, 2'b01, 1, 8'h11, 8'h00, 8'h22, 8'h00, 8'h00, -1,   17,   34, 0, 1'b0);
    tv[9] = mk(2'b01, 2'b01, 0, 8'h0A, 8'h01, 8'h0B, 8'h01, 8'h01, -1,  266,  267, 1, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss", int'(ss), 3);
    chk("rst_start", int'(spi_start), 0);
    chk("rst_upd_err", int'({upd, err}), 0);
    chk("rst_pos", int'(dev0_x | dev0_y | dev1_x | dev1_y), 0);
    chk("rst_btn", int'({dev0_btn, dev1_btn}), 0);
    chk("tx_byte", int'(spi_tx_byte), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(tv[i]);
    chk("one_ss_low", int'(both_low), 0);

    // Reset in the WAIT of byte 3.
    dev_en = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ss != 2'b11) begin ok = 1'b1; break; end
    end
    chk("rr_ss_fall", int'(ok), 1);
    for (int k = 0; k < 4 && ok; k++) begin
      wait_start(s, ok);
      chk("rr_start_seen", int'(ok), 1);
      if (ok && k < 3) drive_done(8'hFF);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rr_ss_immediate", int'(ss), 3);
    @(negedge clk);
    chk("rr_ss", int'(ss), 3);
    chk("rr_pos", int'(dev0_x | dev0_y | dev1_x | dev1_y), 0);
    chk("rr_btn_upd_err", int'({dev0_btn, dev1_btn, upd, err, spi_start}), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    n = 0; first_ss = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ss != 2'b11 && first_ss < 0) first_ss = n;
      if (spi_start) break;
    end
    chk("rr_ss_after_gap", first_ss, POLL);
    chk("rr_first_start", n, POLL + SETUP);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
